// File: rtl/cordic_vector_unit_if.sv
// Handshake and data bundle for the vectoring-mode CORDIC unit.
// The master side drives the request and vector; the slave side returns the angle and magnitude.
interface cordic_vector_unit_if;
   logic        stop;
   logic        start;
   logic [15:0] x_in;
   logic [15:0] y_in;
   logic        busy;
   logic        done;
   logic        range_err;
   logic [15:0] angle_out;
   logic [15:0] mag_out;

   modport master (
      output stop, start, x_in, y_in,
      input  busy, done, range_err, angle_out, mag_out
   );

   modport slave (
      input  stop, start, x_in, y_in,
      output busy, done, range_err, angle_out, mag_out
   );
endinterface

// File: rtl/cordic_vector_unit.sv
// Iterative vectoring-mode CORDIC: converts (x, y) into atan2(y, x) and gain-compensated magnitude.
// One micro-rotation per clock, then a single gain-compensation multiply.
module cordic_vector_unit #(
   parameter int          ITER   = 14,
   parameter logic [15:0] GAIN_K = 16'h26DD
) (
   input  logic                 clk,
   input  logic                 reset,
   cordic_vector_unit_if.slave  bus
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ITER = 2'd1;
   localparam logic [1:0] ST_COMP = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   localparam logic [4:0] LAST_ITER = 5'(ITER - 1);

   function automatic logic signed [15:0] atan_rom(input logic [3:0] idx);
      logic signed [15:0] val;
      case (idx)
         4'd0:    val = 16'sh3243;
         4'd1:    val = 16'sh1DAC;
         4'd2:    val = 16'sh0FAD;
         4'd3:    val = 16'sh07F5;
         4'd4:    val = 16'sh03FE;
         4'd5:    val = 16'sh01FF;
         4'd6:    val = 16'sh00FF;
         4'd7:    val = 16'sh007F;
         4'd8:    val = 16'sh003F;
         4'd9:    val = 16'sh001F;
         4'd10:   val = 16'sh000F;
         4'd11:   val = 16'sh0007;
         4'd12:   val = 16'sh0003;
         4'd13:   val = 16'sh0001;
         default: val = 16'sh0000;
      endcase
      return val;
   endfunction

   logic [1:0]         state_r;
   logic [4:0]         iter_r;
   logic signed [17:0] x_r;
   logic signed [17:0] y_r;
   logic signed [15:0] z_r;
   logic               err_r;
   logic               busy_r;
   logic               done_r;
   logic               range_err_r;
   logic [15:0]        angle_r;
   logic [15:0]        mag_r;

   logic signed [17:0] x_sh_s;
   logic signed [17:0] y_sh_s;
   logic signed [15:0] atan_s;
   logic signed [33:0] prod_s;
   logic signed [33:0] scaled_s;
   logic [15:0]        mag_sat_s;

   // Shifted cross terms, arctangent lookup and saturated gain-compensated magnitude.
   always_comb begin
      x_sh_s    = x_r >>> iter_r[3:0];
      y_sh_s    = y_r >>> iter_r[3:0];
      atan_s    = atan_rom(iter_r[3:0]);
      prod_s    = 34'(x_r) * 34'($signed(GAIN_K));
      scaled_s  = prod_s >>> 14;
      mag_sat_s = 16'h0000;
      if (scaled_s > 34'sd32767) begin
         mag_sat_s = 16'h7FFF;
      end else begin
         mag_sat_s = scaled_s[15:0];
      end
   end

   // Control FSM and datapath registers; everything holds while stop is high.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r     <= ST_IDLE;
         iter_r      <= 5'd0;
         x_r         <= 18'sd0;
         y_r         <= 18'sd0;
         z_r         <= 16'sd0;
         err_r       <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         range_err_r <= 1'b0;
         angle_r     <= 16'h0000;
         mag_r       <= 16'h0000;
      end else if (!bus.stop) begin
         case (state_r)
            ST_IDLE: begin
               if (bus.start) begin
                  busy_r      <= 1'b1;
                  range_err_r <= 1'b0;
                  z_r         <= 16'sd0;
                  iter_r      <= 5'd0;
                  if (bus.x_in[15]) begin
                     // Negative x is rejected; COMP then reports the error one cycle later.
                     err_r   <= 1'b1;
                     state_r <= ST_COMP;
                  end else begin
                     err_r   <= 1'b0;
                     x_r     <= {{2{bus.x_in[15]}}, bus.x_in};
                     y_r     <= {{2{bus.y_in[15]}}, bus.y_in};
                     state_r <= ST_ITER;
                  end
               end
            end
            ST_ITER: begin
               if (!y_r[17]) begin
                  x_r <= x_r + y_sh_s;
                  y_r <= y_r - x_sh_s;
                  z_r <= z_r + atan_s;
               end else begin
                  x_r <= x_r - y_sh_s;
                  y_r <= y_r + x_sh_s;
                  z_r <= z_r - atan_s;
               end
               iter_r <= iter_r + 5'd1;
               if (iter_r == LAST_ITER) begin
                  state_r <= ST_COMP;
               end
            end
            ST_COMP: begin
               if (err_r) begin
                  angle_r     <= 16'h0000;
                  mag_r       <= 16'h0000;
                  range_err_r <= 1'b1;
               end else begin
                  angle_r     <= z_r;
                  mag_r       <= mag_sat_s;
                  range_err_r <= 1'b0;
               end
               busy_r  <= 1'b0;
               done_r  <= 1'b1;
               state_r <= ST_DONE;
            end
            ST_DONE: begin
               done_r  <= 1'b0;
               state_r <= ST_IDLE;
            end
            default: begin
               busy_r  <= 1'b0;
               done_r  <= 1'b0;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.busy      = busy_r;
   assign bus.done      = done_r;
   assign bus.range_err = range_err_r;
   assign bus.angle_out = angle_r;
   assign bus.mag_out   = mag_r;

endmodule

// File: tb/tb_cordic_vector_unit.sv
// Directed self-checking bench for cordic_vector_unit with hand-computed atan2/magnitude targets.
module tb_cordic_vector_unit;

   logic clk;
   logic reset;
   int   checks;
   int   errors;
   int   lat;
   int   pulses;
   int   bad;
   logic [15:0] r_angle;
   logic [15:0] r_mag;
   logic        r_err;
   logic        r_busy;
   logic        r_done_after;
   logic [15:0] ref_angle;
   logic [15:0] ref_mag;

   cordic_vector_unit_if bus ();

   cordic_vector_unit dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp, input int tol);
      int diff;
      checks++;
      diff = int'($signed(obs)) - int'($signed(exp));
      if (diff < -tol || diff > tol) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (tol %0d)", tag, obs, exp, tol);
      end
   endtask

   // Called at a negedge; returns at the negedge where done is first seen (lat = edge index).
   task automatic run_op(input logic [15:0] x, input logic [15:0] y);
      bus.x_in  = x;
      bus.y_in  = y;
      bus.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      lat = 0;
      while (bus.done !== 1'b1 && lat < 60) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      r_angle = bus.angle_out;
      r_mag   = bus.mag_out;
      r_err   = bus.range_err;
      r_busy  = bus.busy;
      @(negedge clk);
      r_done_after = bus.done;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      checks = 0;
      errors = 0;
      reset  = 1'b0;
      bus.stop  = 1'b0;
      bus.start = 1'b0;
      bus.x_in  = 16'h0000;
      bus.y_in  = 16'h0000;
      repeat (3) @(negedge clk);
      check_val("rst_busy",  16'(bus.busy), 16'h0000, 0);
      check_val("rst_done",  16'(bus.done), 16'h0000, 0);
      check_val("rst_err",   16'(bus.range_err), 16'h0000, 0);
      check_val("rst_angle", bus.angle_out, 16'h0000, 0);
      check_val("rst_mag",   bus.mag_out, 16'h0000, 0);
      reset = 1'b1;
      @(negedge clk);

      // +x axis
      run_op(16'h4000, 16'h0000);
      check_val("xaxis_lat",   16'(lat), 16'd15, 0);
      check_val("xaxis_angle", r_angle, 16'h0000, 8);
      check_val("xaxis_mag",   r_mag, 16'h4000, 8);
      check_val("xaxis_err",   16'(r_err), 16'h0000, 0);
      check_val("xaxis_busy",  16'(r_busy), 16'h0000, 0);
      check_val("xaxis_pulse", 16'(r_done_after), 16'h0000, 0);

      // Reset during the 5th iteration clock
      bus.x_in  = 16'h2000;
      bus.y_in  = 16'h2000;
      bus.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      check_val("mrst_busy",  16'(bus.busy), 16'h0000, 0);
      check_val("mrst_done",  16'(bus.done), 16'h0000, 0);
      check_val("mrst_angle", bus.angle_out, 16'h0000, 0);
      check_val("mrst_mag",   bus.mag_out, 16'h0000, 0);
      check_val("mrst_err",   16'(bus.range_err), 16'h0000, 0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      pulses = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (bus.done === 1'b1) pulses++;
      end
      check_val("mrst_nodone", 16'(pulses), 16'd0, 0);
      run_op(16'h2000, 16'h2000);
      check_val("q1_lat",   16'(lat), 16'd15, 0);
      check_val("q1_angle", r_angle, 16'h3244, 8);
      check_val("q1_mag",   r_mag, 16'h2D41, 8);

      // Axis / quadrant points, issued back-to-back
      run_op(16'h0000, 16'h4000);
      check_val("b2b_lat",  16'(lat), 16'd15, 0);
      check_val("yp_angle", r_angle, 16'h6488, 8);
      run_op(16'h0000, 16'hC000);
      check_val("yn_angle", r_angle, 16'h9B78, 8);
      run_op(16'h2000, 16'hE000);
      check_val("q4_angle", r_angle, 16'hCDBD, 8);
      check_val("q4_mag",   r_mag, 16'h2D41, 8);
      ref_angle = r_angle;
      ref_mag   = r_mag;
      run_op(16'h0000, 16'h0000);
      check_val("zero_mag", r_mag, 16'h0000, 8);

      // Saturation
      run_op(16'h7FFF, 16'h7FFF);
      check_val("sat_mag",   r_mag, 16'h7FFF, 0);
      check_val("sat_angle", r_angle, 16'h3244, 8);
      check_val("sat_err",   16'(r_err), 16'h0000, 0);

      // Range error
      run_op(16'h8000, 16'h1000);
      check_val("rerr_lat",   16'(lat), 16'd1, 0);
      check_val("rerr_err",   16'(r_err), 16'h0001, 0);
      check_val("rerr_angle", r_angle, 16'h0000, 0);
      check_val("rerr_mag",   r_mag, 16'h0000, 0);
      check_val("rerr_pulse", 16'(r_done_after), 16'h0000, 0);

      // Start re-pulsed mid-operation and in the DONE cycle must be ignored
      bus.x_in  = 16'h4000;
      bus.y_in  = 16'h0000;
      bus.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      pulses = 0;
      lat = 0;
      for (int cyc = 1; cyc <= 40; cyc++) begin
         @(posedge clk);
         @(negedge clk);
         bus.start = 1'b0;
         if (bus.done === 1'b1) begin
            pulses++;
            if (pulses == 1) begin
               lat     = cyc;
               r_angle = bus.angle_out;
               r_mag   = bus.mag_out;
               r_err   = bus.range_err;
            end
         end
         if (cyc == 3 || cyc == 10 || bus.done === 1'b1) begin
            bus.start = 1'b1;
            bus.x_in  = 16'h0000;
            bus.y_in  = 16'h4000;
         end
      end
      check_val("hs_pulses", 16'(pulses), 16'd1, 0);
      check_val("hs_lat",    16'(lat), 16'd15, 0);
      check_val("hs_angle",  r_angle, 16'h0000, 8);
      check_val("hs_mag",    r_mag, 16'h4000, 8);
      check_val("hs_err",    16'(r_err), 16'h0000, 0);
      check_val("hs_idle",   16'(bus.busy), 16'h0000, 0);

      // Freeze for 7 cycles mid-ITER
      bus.x_in  = 16'h2000;
      bus.y_in  = 16'hE000;
      bus.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      lat = 0;
      bad = 0;
      while (bus.done !== 1'b1 && lat < 80) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (lat == 5) bus.stop = 1'b1;
         if (lat == 12) bus.stop = 1'b0;
         if (bus.stop && (bus.busy !== 1'b1 || bus.done !== 1'b0)) bad++;
      end
      check_val("frz_lat",   16'(lat), 16'd22, 0);
      check_val("frz_hold",  16'(bad), 16'd0, 0);
      check_val("frz_angle", bus.angle_out, ref_angle, 0);
      check_val("frz_mag",   bus.mag_out, ref_mag, 0);

      // Freeze while done is high: done holds, then drops one cycle after release
      bus.stop = 1'b1;
      repeat (3) @(negedge clk);
      check_val("frz_done_hold", 16'(bus.done), 16'h0001, 0);
      bus.stop = 1'b0;
      @(negedge clk);
      check_val("frz_done_drop", 16'(bus.done), 16'h0000, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
